// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and FSM state type for the MAC sequencer
package mac_pkg;

    localparam int DEF_NUM_MAC   = 4;
    localparam int DEF_IN_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_MAC_LAT   = 2;
    localparam int DEF_LEN_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESULT  = 3'd4
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequences N operand beats through an external MAC array
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int NUM_MAC   = DEF_NUM_MAC,
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int MAC_LAT   = DEF_MAC_LAT,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [LEN_WIDTH-1:0]         cmd_len,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [NUM_MAC*IN_WIDTH-1:0]  op_a,
    input  logic [NUM_MAC*IN_WIDTH-1:0]  op_b,
    output logic                         mac_en,
    output logic [NUM_MAC*IN_WIDTH-1:0]  mac_a,
    output logic [NUM_MAC*IN_WIDTH-1:0]  mac_b,
    output logic [NUM_MAC*ACC_WIDTH-1:0] mac_acc_in,
    input  logic [NUM_MAC*ACC_WIDTH-1:0] mac_acc_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [NUM_MAC*ACC_WIDTH-1:0] res_data,
    output logic                         busy
);

    localparam int CW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t                       state;
    logic [LEN_WIDTH-1:0]         remaining;
    logic [CW-1:0]                lat_cnt;
    logic [NUM_MAC*ACC_WIDTH-1:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            lat_cnt   <= '0;
            sum       <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sum       <= '0;
                        remaining <= cmd_len;
                        state     <= (cmd_len == '0) ? ST_RESULT : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (op_valid) begin
                        mac_a   <= op_a;
                        mac_b   <= op_b;
                        lat_cnt <= '0;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // operands and sum stay frozen for the whole enabled window
                    if (lat_cnt == CW'(MAC_LAT - 1)) begin
                        state <= ST_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                ST_CAPTURE: begin
                    sum       <= mac_acc_out;
                    remaining <= remaining - LEN_WIDTH'(1);
                    state     <= (remaining == LEN_WIDTH'(1)) ? ST_RESULT : ST_FETCH;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state == ST_IDLE);
    assign op_ready   = (state == ST_FETCH);
    assign mac_en     = (state == ST_ISSUE);
    assign res_valid  = (state == ST_RESULT);
    assign busy       = (state != ST_IDLE);
    assign mac_acc_in = sum;
    assign res_data   = sum;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - randomized self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;

    localparam int NM  = 4;
    localparam int IW  = 8;
    localparam int AW  = 16;
    localparam int LAT = 2;
    localparam int LW  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [LW-1:0]   cmd_len;
    logic            op_valid;
    logic            op_ready;
    logic [NM*IW-1:0] op_a, op_b;
    logic            mac_en;
    logic [NM*IW-1:0] mac_a, mac_b;
    logic [NM*AW-1:0] mac_acc_in, mac_acc_out;
    logic            res_valid;
    logic            res_ready;
    logic [NM*AW-1:0] res_data;
    logic            busy;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .NUM_MAC(NM), .IN_WIDTH(IW), .ACC_WIDTH(AW), .MAC_LAT(LAT), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    // external MAC array: acc_in + a*b per lane, emerging after LAT enabled cycles
    logic [NM*AW-1:0] pipe [LAT];
    initial for (int j = 0; j < LAT; j++) pipe[j] = '0;
    always @(posedge clk) begin
        if (mac_en) begin
            for (int l = 0; l < NM; l++)
                pipe[0][l*AW +: AW] <= mac_acc_in[l*AW +: AW] + mac_a[l*IW +: IW] * mac_b[l*IW +: IW];
            for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
        end
    end
    assign mac_acc_out = pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] expected_sum(input int n);
        int acc [NM];
        logic [63:0] r;
        for (int l = 0; l < NM; l++) acc[l] = 0;
        for (int k = 0; k < n; k++)
            for (int l = 0; l < NM; l++)
                acc[l] = (acc[l] + int'(qa[k][l*8 +: 8]) * int'(qb[k][l*8 +: 8])) % 65536;
        r = '0;
        for (int l = 0; l < NM; l++) r[l*16 +: 16] = acc[l][15:0];
        return r;
    endfunction

    task automatic fill(input int n, input bit fixed, input logic [31:0] a, input logic [31:0] b);
        qa.delete();
        qb.delete();
        for (int k = 0; k < n; k++) begin
            qa.push_back(fixed ? a : $urandom);
            qb.push_back(fixed ? b : $urandom);
        end
    endtask

    task automatic run_job(input int n, input bit gaps, input int hold);
        logic [63:0] exp;
        int cycles, idx, en_cnt;
        bit hs;
        exp = expected_sum(n);
        @(negedge clk);
        chk("cmd_ready_idle", {63'b0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1;
        cmd_len   = LW'(n);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cycles = 0; idx = 0; en_cnt = 0;
        while (!res_valid && cycles < 5000) begin
            @(negedge clk);
            en_cnt += int'(mac_en);
            op_valid  = gaps ? 1'($urandom % 2) : 1'b1;
            cmd_valid = gaps ? 1'($urandom % 2) : 1'b0;
            cmd_len   = LW'($urandom);
            op_a = (idx < n) ? qa[idx] : $urandom;
            op_b = (idx < n) ? qb[idx] : $urandom;
            hs = op_valid && op_ready;
            @(posedge clk);
            cycles++;
            if (hs) idx++;
            #1;
        end
        cmd_valid = 1'b0;
        op_valid  = 1'b0;
        chk("res_valid_seen", {63'b0, res_valid}, 64'd1);
        if (!gaps) chk("latency", 64'(cycles), 64'(n * (LAT + 2)));
        chk("mac_en_cycles", 64'(en_cnt), 64'(n * LAT));
        chk("beats_taken", 64'(idx), 64'(n));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_data", res_data, exp);
            chk("hold_cmd_ready", {63'b0, cmd_ready}, 64'd0);
            chk("hold_valid", {63'b0, res_valid}, 64'd1);
        end
        @(negedge clk);
        for (int l = 0; l < NM; l++)
            chk($sformatf("lane%0d", l), 64'(res_data[l*AW +: AW]), 64'(exp[l*16 +: 16]));
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk("idle_after", {62'b0, cmd_ready, busy}, 64'b10);
    endtask

    initial begin
        int en;
        int cyc;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; op_valid = 1'b0;
        op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {57'b0, cmd_ready, busy, mac_en, res_valid, op_ready, 2'b0}, 64'b1000000);
        chk("rst_regs", {mac_a, mac_b}, 64'd0);
        chk("rst_res", res_data, 64'd0);
        rst_n = 1'b1;

        fill(1, 1, 32'h30410002, 32'h04030004);
        run_job(1, 0, 0);
        chk("n1_const", res_data, 64'h00C0_00C3_0000_0008);
        fill(3, 1, 32'h30410002, 32'h04030004);
        run_job(3, 0, 0);
        chk("n3_const", res_data, 64'h0240_0249_0000_0018);
        fill(2, 1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_job(2, 0, 0);
        chk("ff_wrap", res_data, {4{16'd64514}});
        fill(0, 0, 0, 0);
        run_job(0, 0, 0);
        chk("n0_zero", res_data, 64'd0);
        fill(1, 0, 0, 0);
        run_job(1, 0, 5);
        fill(255, 0, 0, 0);
        run_job(255, 0, 1);
        for (int t = 0; t < 20; t++) begin
            int n;
            n = $urandom_range(0, 6);
            fill(n, 0, 0, 0);
            run_job(n, 1'($urandom % 2), $urandom_range(0, 3));
        end

        // reset mid-job, during the second beat's ISSUE
        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = LW'(3);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 32'h30410002; op_b = 32'h04030004;
        en = 0; cyc = 0;
        while (en < 3 && cyc < 100) begin
            @(negedge clk);
            if (mac_en) en++;
            cyc++;
        end
        chk("rst_reach_issue", 64'(en), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", {57'b0, cmd_ready, busy, mac_en, res_valid, op_ready, 2'b0}, 64'b1000000);
        chk("midrst_regs", {mac_a, mac_b}, 64'd0);
        chk("midrst_sum", mac_acc_in, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op_valid = 1'b0;
        fill(1, 1, 32'h30410002, 32'h04030004);
        run_job(1, 0, 0);
        chk("post_rst_const", res_data, 64'h00C0_00C3_0000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
